// File: rtl/a_buf_ctrl.sv
// a_buf_ctrl: ping-pong controller for the two A-operand buffer banks.
// Tile-load beats fill bank[wp], and the systolic array drains bank[rp] one row per pulse.
// Optional build macro A_BUF_CTRL_PERF_EN adds saturating load/drain stall counters.
module a_buf_ctrl #(
  parameter int unsigned SARRAY_H          = 8,
  parameter int unsigned A_BUF_NUM         = 2,
  parameter int unsigned SARRAY_LOAD_WIDTH = 64,
  parameter int unsigned TLOAD_DATAW_WIDTH = 3,
  parameter int unsigned TLOAD_DW_BYTE_IDX = 0,
  parameter int unsigned TLOAD_DW_2B_IDX   = 1,
  parameter int unsigned TLOAD_DW_4B_IDX   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         ld_valid_i,
  output logic                         ld_ready_o,
  input  logic [TLOAD_DATAW_WIDTH-1:0] ld_data_width_i,
  input  logic [SARRAY_LOAD_WIDTH-1:0] ld_data_i,
  output logic                         wr_a_buf_valid_o,
  output logic [0:0]                   wr_a_buf_id_o,
  output logic [TLOAD_DATAW_WIDTH-1:0] wr_a_buf_data_width_o,
  output logic [SARRAY_LOAD_WIDTH-1:0] wr_a_buf_data_o,
  input  logic                         sa_rd_ready_i,
  output logic                         rd_a_buf_valid_o,
  output logic                         rd_a_buf_id_o,
  output logic                         rd_last_o,
  output logic [1:0]                   buf_full_o,
  output logic [1:0]                   buf_empty_o
`ifdef A_BUF_CTRL_PERF_EN
  ,
  output logic [31:0]                  ld_stall_cnt_o,
  output logic [31:0]                  drain_stall_cnt_o
`endif
);

  localparam int unsigned FILL_CNT_W = $clog2(4 * SARRAY_H) + 1;
  localparam int unsigned DRN_CNT_W  = $clog2(SARRAY_H) + 1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_e;

  bank_st_e                     bank_st_q [A_BUF_NUM];
  bank_st_e                     bank_st_d [A_BUF_NUM];
  logic [TLOAD_DATAW_WIDTH-1:0] width_q   [A_BUF_NUM];
  logic [TLOAD_DATAW_WIDTH-1:0] width_d   [A_BUF_NUM];
  logic                         wp_q, wp_d;
  logic                         rp_q, rp_d;
  logic [FILL_CNT_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [DRN_CNT_W-1:0]         drn_cnt_q, drn_cnt_d;
  logic [FILL_CNT_W-1:0]        fill_tgt;
  bank_st_e                     wr_st;
  bank_st_e                     rd_st;

  // Bank bookkeeping: handshake outputs plus next-state for fill and drain sides.
  always_comb begin
    bank_st_d  = bank_st_q;
    width_d    = width_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    fill_cnt_d = fill_cnt_q;
    drn_cnt_d  = drn_cnt_q;
    fill_tgt   = FILL_CNT_W'(4 * SARRAY_H);

    wr_st = bank_st_q[wp_q];
    rd_st = bank_st_q[rp_q];

    ld_ready_o            = rst_n & ~flush_i & ((wr_st == ST_EMPTY) | (wr_st == ST_FILLING));
    wr_a_buf_valid_o      = ld_valid_i & ld_ready_o;
    wr_a_buf_id_o         = wp_q;
    wr_a_buf_data_o       = ld_data_i;
    wr_a_buf_data_width_o = (wr_st == ST_EMPTY) ? ld_data_width_i : width_q[wp_q];

    // Narrower elements pack more beats into one tile.
    if (wr_a_buf_data_width_o[TLOAD_DW_BYTE_IDX]) begin
      fill_tgt = FILL_CNT_W'(4 * SARRAY_H);
    end else if (wr_a_buf_data_width_o[TLOAD_DW_2B_IDX]) begin
      fill_tgt = FILL_CNT_W'(2 * SARRAY_H);
    end else if (wr_a_buf_data_width_o[TLOAD_DW_4B_IDX]) begin
      fill_tgt = FILL_CNT_W'(SARRAY_H);
    end

    rd_a_buf_valid_o = rst_n & ~flush_i & sa_rd_ready_i &
                       ((rd_st == ST_FULL) | (rd_st == ST_DRAINING));
    rd_a_buf_id_o    = rp_q;
    rd_last_o        = rd_a_buf_valid_o & (drn_cnt_q == DRN_CNT_W'(SARRAY_H - 1));

    if (flush_i) begin
      for (int b = 0; b < A_BUF_NUM; b++) begin
        bank_st_d[b] = ST_EMPTY;
        width_d[b]   = '0;
      end
      wp_d       = 1'b0;
      rp_d       = 1'b0;
      fill_cnt_d = '0;
      drn_cnt_d  = '0;
    end else begin
      // The write bank is EMPTY/FILLING and the read bank FULL/DRAINING, so they never collide.
      if (wr_a_buf_valid_o) begin
        if (wr_st == ST_EMPTY) begin
          width_d[wp_q] = ld_data_width_i;
        end
        if ((fill_cnt_q + FILL_CNT_W'(1)) == fill_tgt) begin
          bank_st_d[wp_q] = ST_FULL;
          fill_cnt_d      = '0;
          wp_d            = ~wp_q;
        end else begin
          bank_st_d[wp_q] = ST_FILLING;
          fill_cnt_d      = fill_cnt_q + FILL_CNT_W'(1);
        end
      end
      if (rd_a_buf_valid_o) begin
        if (rd_last_o) begin
          bank_st_d[rp_q] = ST_EMPTY;
          drn_cnt_d       = '0;
          rp_d            = ~rp_q;
        end else begin
          bank_st_d[rp_q] = ST_DRAINING;
          drn_cnt_d       = drn_cnt_q + DRN_CNT_W'(1);
        end
      end
    end
  end

  // Per-bank status flags.
  always_comb begin
    buf_full_o  = '0;
    buf_empty_o = '0;
    for (int b = 0; b < A_BUF_NUM; b++) begin
      buf_full_o[b]  = (bank_st_q[b] == ST_FULL);
      buf_empty_o[b] = (bank_st_q[b] == ST_EMPTY);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < A_BUF_NUM; b++) begin
        bank_st_q[b] <= ST_EMPTY;
        width_q[b]   <= '0;
      end
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      fill_cnt_q <= '0;
      drn_cnt_q  <= '0;
    end else begin
      bank_st_q  <= bank_st_d;
      width_q    <= width_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      fill_cnt_q <= fill_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
    end
  end

`ifdef A_BUF_CTRL_PERF_EN
  logic [31:0] ld_stall_cnt_q, ld_stall_cnt_d;
  logic [31:0] drn_stall_cnt_q, drn_stall_cnt_d;

  // Saturating stall counters, cleared by flush.
  always_comb begin
    ld_stall_cnt_d  = ld_stall_cnt_q;
    drn_stall_cnt_d = drn_stall_cnt_q;
    if (flush_i) begin
      ld_stall_cnt_d  = '0;
      drn_stall_cnt_d = '0;
    end else begin
      if (ld_valid_i & ~ld_ready_o & (ld_stall_cnt_q != '1)) begin
        ld_stall_cnt_d = ld_stall_cnt_q + 32'd1;
      end
      if (((rd_st == ST_FULL) | (rd_st == ST_DRAINING)) & ~sa_rd_ready_i &
          (drn_stall_cnt_q != '1)) begin
        drn_stall_cnt_d = drn_stall_cnt_q + 32'd1;
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_stall_cnt_q  <= '0;
      drn_stall_cnt_q <= '0;
    end else begin
      ld_stall_cnt_q  <= ld_stall_cnt_d;
      drn_stall_cnt_q <= drn_stall_cnt_d;
    end
  end

  assign ld_stall_cnt_o    = ld_stall_cnt_q;
  assign drain_stall_cnt_o = drn_stall_cnt_q;
`else
  // Stall counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_a_buf_ctrl.sv
// tb_a_buf_ctrl: directed scenarios plus randomized traffic against a tile-counting model.
// The model tracks tiles completed/drained and beats/pulses in flight, not bank states.
module tb_a_buf_ctrl;

  localparam int unsigned H  = 8;
  localparam int unsigned LW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic [2:0]    ld_data_width_i;
  logic [LW-1:0] ld_data_i;
  logic          wr_a_buf_valid_o;
  logic [0:0]    wr_a_buf_id_o;
  logic [2:0]    wr_a_buf_data_width_o;
  logic [LW-1:0] wr_a_buf_data_o;
  logic          sa_rd_ready_i;
  logic          rd_a_buf_valid_o;
  logic          rd_a_buf_id_o;
  logic          rd_last_o;
  logic [1:0]    buf_full_o;
  logic [1:0]    buf_empty_o;
`ifdef A_BUF_CTRL_PERF_EN
  logic [31:0]   ld_stall_cnt_o;
  logic [31:0]   drain_stall_cnt_o;
`endif

  a_buf_ctrl #(.SARRAY_H(H), .A_BUF_NUM(2), .SARRAY_LOAD_WIDTH(LW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .flush_i               (flush_i),
    .ld_valid_i            (ld_valid_i),
    .ld_ready_o            (ld_ready_o),
    .ld_data_width_i       (ld_data_width_i),
    .ld_data_i             (ld_data_i),
    .wr_a_buf_valid_o      (wr_a_buf_valid_o),
    .wr_a_buf_id_o         (wr_a_buf_id_o),
    .wr_a_buf_data_width_o (wr_a_buf_data_width_o),
    .wr_a_buf_data_o       (wr_a_buf_data_o),
    .sa_rd_ready_i         (sa_rd_ready_i),
    .rd_a_buf_valid_o      (rd_a_buf_valid_o),
    .rd_a_buf_id_o         (rd_a_buf_id_o),
    .rd_last_o             (rd_last_o),
    .buf_full_o            (buf_full_o),
    .buf_empty_o           (buf_empty_o)
`ifdef A_BUF_CTRL_PERF_EN
    ,
    .ld_stall_cnt_o        (ld_stall_cnt_o),
    .drain_stall_cnt_o     (drain_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: tiles completed / drained, progress of the current fill and drain.
  int         tiles_done, tiles_drained, fill_beats, drain_pulses;
  logic [2:0] fill_w;
  longint     ld_stall_m, drn_stall_m;

  // Observation counters for directed scenarios.
  int n_rd_seen, n_last_seen, n_wr_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int elem_bytes(input logic [2:0] w);
    if (w[0]) return 1;
    if (w[1]) return 2;
    if (w[2]) return 4;
    return 1;
  endfunction

  task automatic model_clear();
    tiles_done = 0; tiles_drained = 0; fill_beats = 0; drain_pulses = 0;
    fill_w = 3'b000; ld_stall_m = 0; drn_stall_m = 0;
  endtask

  task automatic cycle(input bit v, input logic [2:0] w, input bit rdy, input bit fl, input bit rst);
    int         occ;
    bit         e_ready, e_wr, e_rd, e_last;
    logic [2:0] e_ww;
    logic [1:0] e_full, e_empty;
    @(negedge clk);
    rst_n           = !rst;
    flush_i         = fl;
    ld_valid_i      = v;
    ld_data_width_i = w;
    sa_rd_ready_i   = rdy;
    ld_data_i       = {$urandom(), $urandom()};
    #1;
    if (wr_a_buf_valid_o) n_wr_seen++;
    if (rd_a_buf_valid_o) n_rd_seen++;
    if (rd_last_o)        n_last_seen++;
    if (rst) begin
      check("rst_ld_ready", 64'(ld_ready_o), 0);
      check("rst_wr_valid", 64'(wr_a_buf_valid_o), 0);
      check("rst_rd_valid", 64'(rd_a_buf_valid_o), 0);
      check("rst_rd_last",  64'(rd_last_o), 0);
      check("rst_full",     64'(buf_full_o), 0);
      check("rst_empty",    64'(buf_empty_o), 3);
`ifdef A_BUF_CTRL_PERF_EN
      check("rst_ld_stall",  64'(ld_stall_cnt_o), 0);
      check("rst_drn_stall", 64'(drain_stall_cnt_o), 0);
`endif
      model_clear();
    end else begin
      occ     = tiles_done - tiles_drained;
      e_ready = !fl && (occ < 2);
      e_wr    = e_ready && v;
      e_ww    = (fill_beats == 0) ? w : fill_w;
      e_rd    = !fl && rdy && (occ > 0);
      e_last  = e_rd && (drain_pulses == H - 1);
      e_full  = 2'b00;
      e_empty = 2'b11;
      for (int k = tiles_drained; k < tiles_done; k++) begin
        e_empty[k % 2] = 1'b0;
        e_full[k % 2]  = !(k == tiles_drained && drain_pulses > 0);
      end
      if (fill_beats > 0) e_empty[tiles_done % 2] = 1'b0;

      check("ld_ready", 64'(ld_ready_o), 64'(e_ready));
      check("wr_valid", 64'(wr_a_buf_valid_o), 64'(e_wr));
      if (e_wr) begin
        check("wr_id",    64'(wr_a_buf_id_o), 64'(tiles_done % 2));
        check("wr_width", 64'(wr_a_buf_data_width_o), 64'(e_ww));
        check("wr_data",  64'(wr_a_buf_data_o), 64'(ld_data_i));
      end
      check("rd_valid", 64'(rd_a_buf_valid_o), 64'(e_rd));
      if (e_rd) check("rd_id", 64'(rd_a_buf_id_o), 64'(tiles_drained % 2));
      check("rd_last",   64'(rd_last_o), 64'(e_last));
      check("buf_full",  64'(buf_full_o), 64'(e_full));
      check("buf_empty", 64'(buf_empty_o), 64'(e_empty));
`ifdef A_BUF_CTRL_PERF_EN
      check("ld_stall",  64'(ld_stall_cnt_o), 64'(ld_stall_m));
      check("drn_stall", 64'(drain_stall_cnt_o), 64'(drn_stall_m));
`endif
      if (fl) begin
        model_clear();
      end else begin
        if (v && !e_ready && ld_stall_m < 64'hFFFF_FFFF) ld_stall_m++;
        if (occ > 0 && !rdy && drn_stall_m < 64'hFFFF_FFFF) drn_stall_m++;
        if (e_wr) begin
          if (fill_beats == 0) fill_w = w;
          fill_beats++;
          if (fill_beats == (4 * H) / elem_bytes(fill_w)) begin
            tiles_done++;
            fill_beats = 0;
          end
        end
        if (e_rd) begin
          drain_pulses++;
          if (drain_pulses == H) begin
            tiles_drained++;
            drain_pulses = 0;
          end
        end
      end
    end
  endtask

  task automatic clear_seen();
    n_rd_seen = 0; n_last_seen = 0; n_wr_seen = 0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; ld_valid_i = 1'b0; sa_rd_ready_i = 1'b0;
    ld_data_width_i = 3'b000; ld_data_i = '0;
    model_clear();
    clear_seen();

    // Reset.
    for (int i = 0; i < 2; i++) cycle(0, 3'b000, 0, 0, 1);

    // 8 back-to-back 4byte beats fill bank 0.
    clear_seen();
    for (int i = 0; i < 8; i++) cycle(1, 3'b100, 0, 0, 0);
    check("s1_wr_beats", 64'(n_wr_seen), 8);
    cycle(0, 3'b000, 0, 0, 0);
    check("s1_full", 64'(buf_full_o), 64'(2'b01));

    // 32 byte beats into bank 1, width input changes to 4byte on beat 5.
    clear_seen();
    for (int i = 0; i < 32; i++) cycle(1, (i >= 4) ? 3'b100 : 3'b001, 0, 0, 0);
    check("s2_wr_beats", 64'(n_wr_seen), 32);

    // Both full: loads stall, then drain bank 0 with ready toggling.
    clear_seen();
    for (int i = 0; i < 3; i++) cycle(1, 3'b100, 0, 0, 0);
    check("s3_stalled_wr", 64'(n_wr_seen), 0);
    for (int i = 0; i < 16; i++) cycle(1, 3'b100, (i % 2) == 0, 0, 0);
    check("s3_rd_pulses", 64'(n_rd_seen), 8);
    check("s3_rd_last",   64'(n_last_seen), 1);
    check("s3_wr_after",  64'(n_wr_seen), 1);

    // Concurrent drain of bank 0 and 2byte fill of bank 1.
    cycle(0, 3'b000, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 3'b100, 0, 0, 0);
    clear_seen();
    for (int i = 0; i < 16; i++) cycle(1, 3'b010, 1, 0, 0);
    check("s4_wr_beats",  64'(n_wr_seen), 16);
    check("s4_rd_pulses", 64'(n_rd_seen), 8);
    cycle(0, 3'b000, 0, 0, 0);
    check("s4_full", 64'(buf_full_o), 64'(2'b10));

    // Flush on the third drain pulse.
    clear_seen();
    cycle(0, 3'b000, 1, 0, 0);
    cycle(0, 3'b000, 1, 0, 0);
    cycle(0, 3'b000, 1, 1, 0);
    check("s5_rd_pulses", 64'(n_rd_seen), 2);
    cycle(0, 3'b000, 1, 0, 0);
    check("s5_empty", 64'(buf_empty_o), 3);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            3'(3'b001 << $urandom_range(0, 2)),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/a_buf_ctrl.md
A_BUF_CTRL -- requirements
Module: a_buf_ctrl

Interface
REQ-001: Parameter SARRAY_H, default 8: systolic array height, which is the number of shift registers per row and the number of rows per a_buf bank.
REQ-002: Parameter A_BUF_NUM, default 2: number of a_buf banks; only the value 2 is supported.
REQ-003: clk  input  1  single clock for the block.
REQ-004: rst_n  input  1  reset, asynchronous and active-low.
REQ-005: flush_i  input  1  synchronous abort; returns all state to empty.
REQ-006: ld_valid_i  input  1  tile-load beat valid.
REQ-007: ld_ready_o  output  1  tile-load beat accepted.
REQ-008: ld_data_width_i  input  TLOAD_DATAW_WIDTH  one-hot element width (byte, 2byte or 4byte) at the TLOAD_DW_*_IDX bit positions.
REQ-009: ld_data_i  input  SARRAY_LOAD_WIDTH  beat payload.
REQ-010: wr_a_buf_valid_o, wr_a_buf_id_o[0:0], wr_a_buf_data_width_o, wr_a_buf_data_o  outputs  write port to a_buf.
REQ-011: sa_rd_ready_i  input  1  array is ready to consume one A row this cycle.
REQ-012: rd_a_buf_valid_o  output  1  shift-out pulse to a_buf.
REQ-013: rd_a_buf_id_o  output  1  bank being drained.
REQ-014: rd_last_o  output  1  asserted with the final shift-out pulse of a bank.
REQ-015: buf_full_o  output  2  per-bank FULL status.
REQ-016: buf_empty_o  output  2  per-bank EMPTY status.

Function
REQ-017: Each bank SHALL have a state from {EMPTY, FILLING, FULL, DRAINING}, plus a write pointer wp and a read pointer rp, each 1 bit.
REQ-018: ld_ready_o SHALL be 1 iff bank[wp] is EMPTY or FILLING and flush_i is 0; it is a function of registered state and flush_i only.
REQ-019: wr_a_buf_valid_o SHALL equal ld_valid_i & ld_ready_o with zero latency; wr_a_buf_id_o SHALL equal wp; wr_a_buf_data_o SHALL equal ld_data_i.
REQ-020: On the first accepted beat into an EMPTY bank, the block SHALL latch ld_data_width_i as the bank width and move the bank to FILLING; wr_a_buf_data_width_o SHALL be ld_data_width_i on that beat and the latched width on every later beat of the fill.
REQ-021: The fill target SHALL be 4*SARRAY_H beats for byte width, 2*SARRAY_H for 2byte and SARRAY_H for 4byte, counted with a beat counter of clog2(4*SARRAY_H)+1 bits.
REQ-022: The beat that reaches the fill target SHALL move the bank to FULL, clear the counter and toggle wp, all effective the next cycle.
REQ-023: rd_a_buf_valid_o SHALL equal sa_rd_ready_i & (bank[rp] is FULL or DRAINING) & !flush_i; rd_a_buf_id_o SHALL equal rp.
REQ-024: The first pulse SHALL move bank[rp] to DRAINING; a drain counter SHALL count pulses, and a low sa_rd_ready_i SHALL pause the drain without losing the count.
REQ-025: The SARRAY_H-th pulse SHALL assert rd_last_o, move the bank to EMPTY and toggle rp.
REQ-026: A fill of one bank and a drain of the other in the same cycle SHALL both proceed; one bank SHALL never be written and read in the same cycle.
REQ-027: A bank that becomes EMPTY SHALL be writable in the following cycle, with ld_ready_o = 1.
REQ-028: When both banks are FULL, ld_ready_o SHALL be 0 until a drain completes.
REQ-029: flush_i SHALL take precedence over all other events: all outputs are suppressed that cycle, and next cycle both banks are EMPTY with wp = rp = 0 and both counters 0.
REQ-030: buf_full_o[n] SHALL be 1 iff bank n is FULL; buf_empty_o[n] SHALL be 1 iff bank n is EMPTY.

Reset
REQ-031: While rst_n = 0: both banks EMPTY, wp = rp = 0, counters and latched widths 0.
REQ-032: While rst_n = 0: ld_ready_o = 0, wr_a_buf_valid_o = 0, rd_a_buf_valid_o = 0, rd_last_o = 0, buf_full_o = 2'b00, buf_empty_o = 2'b11.
REQ-033: Reset asserted mid-fill or mid-drain SHALL abandon the operation without emitting any further pulse.

Configuration
REQ-034: With A_BUF_CTRL_PERF_EN defined, the block SHALL add 32-bit outputs ld_stall_cnt_o and drain_stall_cnt_o.
REQ-035: ld_stall_cnt_o SHALL increment on ld_valid_i & !ld_ready_o; drain_stall_cnt_o SHALL increment when bank[rp] is FULL or DRAINING and sa_rd_ready_i = 0.
REQ-036: Both counters SHALL saturate at 0xFFFFFFFF and clear on reset or flush_i.
REQ-037: Without A_BUF_CTRL_PERF_EN, the block SHALL have neither port nor either counter, and all other behaviour SHALL be identical.

Verification
REQ-038: SARRAY_H=8, 8 back-to-back 4byte beats -> 8 write pulses with id 0; buf_full_o = 01 next cycle; wp = 1.
REQ-039: 32 byte-width beats with ld_data_width_i changed to 4byte on beat 5 -> all 32 pulses carry byte width; FULL only after beat 32.
REQ-040: Bank 0 FULL, sa_rd_ready_i toggling 1,0,1,... -> exactly 8 rd pulses with id 0, rd_last_o on the 8th, bank 0 EMPTY next cycle.
REQ-041: Both banks FULL with ld_valid_i held -> ld_ready_o = 0 until rd_last_o, then ld_ready_o = 1 the next cycle with wr id = 0.
REQ-042: Drain of bank 0 concurrent with a 2byte fill of bank 1 over 16 beats -> no stall on either side; both operations complete.
REQ-043: flush_i asserted on the 3rd drain pulse -> no rd pulse that cycle; buf_empty_o = 11 next cycle; with A_BUF_CTRL_PERF_EN, both counters read 0.
